// File: rtl/limp_actuator.sv
// Irrigation valve sequencer: turns the controller's mode code into timed
// fertilizer-dose and drain/flush valve sequences, with done/fault reporting.
module limp_actuator #(
    parameter int unsigned DOSE_CYCLES  = 8,
    parameter int unsigned DRAIN_CYCLES = 16,
    parameter int unsigned FLUSH_CYCLES = 4,
    parameter int unsigned CW           = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       low,
    output logic       valve_fert,
    output logic       valve_drain,
    output logic       valve_fill,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [2:0] phase
);

    localparam logic [1:0] MODE_NADA    = 2'b00;
    localparam logic [1:0] MODE_ADB     = 2'b01;
    localparam logic [1:0] MODE_LIMP    = 2'b10;
    localparam logic [1:0] MODE_ILLEGAL = 2'b11;

    localparam logic [CW-1:0] DOSE_LAST  = CW'(DOSE_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);
    localparam logic [CW-1:0] FLUSH_LAST = CW'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DOSE  = 3'd1,
        DRAIN = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4,
        HOLD  = 3'd5,
        FAULT = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          counting;
    logic          fert_d, drain_d, fill_d, busy_d, done_d, fault_d;

    assign counting = (state_q == DOSE) || (state_q == DRAIN) || (state_q == FLUSH);

    // Next state, counter and output decode of the next state
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        fert_d  = 1'b0;
        drain_d = 1'b0;
        fill_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        fault_d = 1'b0;

        if (mode == MODE_ILLEGAL && state_q != FAULT) begin
            state_d = FAULT;
        end else if (mode == MODE_NADA && counting) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mode == MODE_ADB)       state_d = DOSE;
                    else if (mode == MODE_LIMP) state_d = DRAIN;
                end
                DOSE:    if (cnt_q == DOSE_LAST) state_d = DONE;
                DRAIN:   if (low || cnt_q == DRAIN_LAST) state_d = FLUSH;
                FLUSH:   if (cnt_q == FLUSH_LAST) state_d = DONE;
                DONE:    state_d = HOLD;
                HOLD:    if (mode == MODE_NADA) state_d = IDLE;
                FAULT:   state_d = FAULT;
                default: state_d = IDLE;
            endcase
        end

        // Counter runs only while staying in the same counting state; any entry clears it
        if (counting && state_d == state_q) begin
            cnt_d = cnt_q + CW'(1);
        end

        fert_d  = (state_d == DOSE);
        drain_d = (state_d == DRAIN) || (state_d == FLUSH);
        fill_d  = (state_d == FLUSH);
        busy_d  = (state_d == DOSE) || (state_d == DRAIN) || (state_d == FLUSH);
        done_d  = (state_d == DONE);
        fault_d = (state_d == FAULT);
    end

    // State, counter and registered Moore outputs; reset closes valves at once
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            valve_fert  <= 1'b0;
            valve_drain <= 1'b0;
            valve_fill  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fault       <= 1'b0;
            phase       <= 3'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            valve_fert  <= fert_d;
            valve_drain <= drain_d;
            valve_fill  <= fill_d;
            busy        <= busy_d;
            done        <= done_d;
            fault       <= fault_d;
            phase       <= 3'(state_d);
        end
    end

endmodule

// File: doc/limp_actuator.md
Name: limp_actuator

Overview:
- Consumer end of the 2-bit mode code produced by the irrigation mode controller: NADA=00, ADB=01, LIMP=10.
- Turns each mode into timed valve sequences:
  - fertilizer dose for ADB.
  - drain then flush for LIMP.
- Reports completion and faults back to the supervisor.
- Sits between the mode controller and the valve drivers. All outputs are decoded from registered state (Moore).

Parameters:
- DOSE_CYCLES, 8, number of cycles valve_fert stays open per ADB command (>=1).
- DRAIN_CYCLES, 16, maximum cycles valve_drain stays open in LIMP before flushing (>=1).
- FLUSH_CYCLES, 4, cycles valve_fill and valve_drain are both open in flush (>=1).
- CW, 5, counter width; must hold max(DOSE_CYCLES, DRAIN_CYCLES, FLUSH_CYCLES)-1.

Ports:
- clock, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous active-low reset.
- mode, input, 2, mode code from the controller: 00 NADA, 01 ADB, 10 LIMP, 11 illegal.
- low, input, 1, tank-level-low sensor; 1 = tank empty.
- valve_fert, output, 1, fertilizer valve open.
- valve_drain, output, 1, drain valve open.
- valve_fill, output, 1, fill valve open.
- busy, output, 1, high in DOSE, DRAIN or FLUSH.
- done, output, 1, one-cycle pulse at sequence completion.
- fault, output, 1, sticky illegal-mode flag.
- phase, output, 3, current state code for debug.

Behaviour:
- Reset (reset=0, asynchronous, independent of clock):
  - State goes to IDLE; counter goes to 0.
  - All valves, busy, done and fault are 0; phase=000.
  - Reset asserted mid-sequence closes all valves immediately, with no clock edge required.
- State codes (phase): IDLE=0, DOSE=1, DRAIN=2, FLUSH=3, DONE=4, HOLD=5, FAULT=7.
- mode is sampled only on the rising edge of clock.
- Transition priority at each edge:
  1. mode==11 in any state except FAULT → FAULT.
  2. mode==00 in DOSE, DRAIN or FLUSH → IDLE (abort). All valves close next cycle and done is not pulsed.
  3. Normal transitions below.
- IDLE:
  - mode 01 → DOSE.
  - mode 10 → DRAIN.
  - mode 00 → stay in IDLE.
  - Counter is cleared on every entry to DOSE, DRAIN and FLUSH.
- DOSE:
  - valve_fert=1.
  - Counter increments each cycle; when counter==DOSE_CYCLES-1 → DONE.
  - valve_fert is high for exactly DOSE_CYCLES cycles.
  - low is ignored in DOSE.
- DRAIN:
  - valve_drain=1.
  - Exits to FLUSH when low==1 or counter==DRAIN_CYCLES-1, whichever comes first.
  - If low is already 1 on the first DRAIN cycle, DRAIN lasts exactly 1 cycle.
- FLUSH:
  - valve_fill=1 and valve_drain=1.
  - When counter==FLUSH_CYCLES-1 → DONE.
  - low is ignored in FLUSH.
- DONE:
  - done=1 for exactly one cycle, all valves 0.
  - Next state is HOLD unconditionally, unless mode==11, which goes to FAULT.
- HOLD:
  - All valves 0.
  - Stays in HOLD until mode==00, then → IDLE.
  - This prevents retriggering while the controller still drives 01 or 10.
- FAULT:
  - fault=1, all valves 0.
  - Only reset exits FAULT.
- A mode change between 01 and 10 during DOSE, DRAIN or FLUSH is ignored; the running sequence completes.
- Invariants, every cycle:
  - valve_fert and valve_drain are never both 1.
  - valve_fill is 1 only in FLUSH.
  - busy = (state is DOSE, DRAIN or FLUSH).
- Counter is CW bits wide and never wraps: it exits on terminal count, and leaving a counting state by any path stops it.
- Outputs have no combinational path from inputs.
- Latency: with mode=01 sampled at edge k:
  - valve_fert rises after edge k and falls after edge k+DOSE_CYCLES.
  - done is high for the cycle after edge k+DOSE_CYCLES.

Test Plan:
- Reset, then mode=01 held → valve_fert high exactly 8 cycles, then done=1 for 1 cycle, then phase=5. With mode still 01, no second dose. Drive mode=00 → phase=0 next cycle.
- mode=10, low=0 throughout → valve_drain high for 16 cycles. Then fill+drain both high for 4 cycles, then done pulse. valve_fert stays 0 throughout.
- mode=10, low rises on the 5th DRAIN cycle → FLUSH entered at the next edge: drain-only lasts 5 cycles, then 4 flush cycles, then done.
- Mode=01 and drive mode=00 at DOSE cycle 3 → valve_fert low the next cycle, phase=0, no done pulse. A fresh mode=01 then gives a full 8-cycle dose.
- mode=11 during FLUSH → phase=7, fault=1, all valves 0. fault stays high across mode=00/01/10 for 20 cycles; only reset=0 clears fault and gives phase=0.
- Assert reset=0 between clock edges mid-DRAIN → valve_drain drops without a clock edge. After release with mode=00, all outputs stay 0.
